// File: rtl/alert_monitor.sv
// Alert conditioning for the piezo driver: debounced battery-low with hysteresis,
// overspeed with minimum hold time and release band, and a steering-gated moving flag.
module alert_monitor #(
  parameter logic [11:0] BATT_LOW_TH = 12'h800,
  parameter logic [11:0] BATT_HYST   = 12'h040,
  parameter int unsigned BATT_CNT    = 16,
  parameter logic [11:0] OVR_SPD_TH  = 12'd1536,
  parameter logic [11:0] SPD_HYST    = 12'd64,
  parameter int unsigned OVR_HOLD    = 25000000,
  parameter logic [11:0] MOVE_TH     = 12'd32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [11:0]              batt,
  input  logic                     batt_vld,
  input  logic signed [11:0]       spd,
  input  logic                     spd_vld,
  input  logic                     en_steer,
  output logic                     moving,
  output logic                     ovr_spd,
  output logic                     batt_low
);

  localparam int DATA_W = 12;
  localparam int HOLD_W = (OVR_HOLD < 2) ? 1 : $clog2(OVR_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(OVR_HOLD);
  localparam logic [7:0]        CNT_TGT     = 8'(BATT_CNT);
  localparam logic [DATA_W-1:0] REL_TH      = (SPD_HYST > OVR_SPD_TH) ? '0 : OVR_SPD_TH - SPD_HYST;

  // |v| with the most negative code clamped to the largest positive code.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
    if (!v[DATA_W-1])
      return $unsigned(v);
    else if (v[DATA_W-2:0] == '0)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return $unsigned(-v);
  endfunction

  function automatic logic [DATA_W-1:0] rec_th_sat(input logic [DATA_W-1:0] th,
                                                   input logic [DATA_W-1:0] hyst);
    logic [DATA_W:0] s;
    s = {1'b0, th} + {1'b0, hyst};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  localparam logic [DATA_W-1:0] REC_TH = rec_th_sat(BATT_LOW_TH, BATT_HYST);

  typedef enum logic [1:0] {BOK, BLOW_PEND, BLOW, BOK_PEND} batt_st_e;

  batt_st_e          state_q;
  logic [7:0]        cnt_q;
  logic              batt_low_q;

  logic [DATA_W-1:0] mag_q, mag_d;
  logic              upd_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ovr_q, ovr_d;
  logic              moving_q, moving_d;
  logic              is_low, is_rec, over;

  assign is_low = batt < BATT_LOW_TH;
  assign is_rec = batt >= REC_TH;

  // Battery debounce FSM; advances only on strobed samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOK;
      cnt_q      <= '0;
      batt_low_q <= 1'b0;
    end else if (batt_vld) begin
      case (state_q)
        BOK: if (is_low) begin
          if (CNT_TGT <= 8'd1) begin
            state_q    <= BLOW;
            cnt_q      <= '0;
            batt_low_q <= 1'b1;
          end else begin
            state_q <= BLOW_PEND;
            cnt_q   <= 8'd1;
          end
        end
        BLOW_PEND: if (is_low) begin
          if (cnt_q + 8'd1 >= CNT_TGT) begin
            state_q    <= BLOW;
            cnt_q      <= '0;
            batt_low_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end else begin
          state_q <= BOK;
          cnt_q   <= '0;
        end
        BLOW: if (is_rec) begin
          if (CNT_TGT <= 8'd1) begin
            state_q    <= BOK;
            cnt_q      <= '0;
            batt_low_q <= 1'b0;
          end else begin
            state_q <= BOK_PEND;
            cnt_q   <= 8'd1;
          end
        end
        BOK_PEND: if (is_rec) begin
          if (cnt_q + 8'd1 >= CNT_TGT) begin
            state_q    <= BOK;
            cnt_q      <= '0;
            batt_low_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end else begin
          state_q <= BLOW;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= BOK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Overspeed is judged only on a freshly captured magnitude; the hold
  // counter then keeps the alert up so the piezo pattern cannot chatter.
  always_comb begin
    mag_d    = spd_vld ? abs_sat(spd) : mag_q;
    over     = upd_q && (mag_q > OVR_SPD_TH);
    hold_d   = hold_q;
    ovr_d    = ovr_q;
    if (over) begin
      hold_d = HOLD_RELOAD;
      ovr_d  = 1'b1;
    end else begin
      if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
      if (hold_d == '0 && mag_q <= REL_TH) ovr_d = 1'b0;
    end
    moving_d = en_steer && (mag_q >= MOVE_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q    <= '0;
      upd_q    <= 1'b0;
      hold_q   <= '0;
      ovr_q    <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      mag_q    <= mag_d;
      upd_q    <= spd_vld;
      hold_q   <= hold_d;
      ovr_q    <= ovr_d;
      moving_q <= moving_d;
    end
  end

  assign moving   = moving_q;
  assign ovr_spd  = ovr_q;
  assign batt_low = batt_low_q;

endmodule

// File: tb/tb_alert_monitor.sv
// Scoreboard bench for alert_monitor: directed stimulus queues expected flags
// tagged with the cycle they must appear; a negedge monitor pops and compares.
module tb_alert_monitor;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [11:0]        batt = '0;
  logic               batt_vld = 1'b0;
  logic signed [11:0] spd = '0;
  logic               spd_vld = 1'b0;
  logic               en_steer = 1'b0;
  logic               moving, ovr_spd, batt_low;

  alert_monitor #(.OVR_HOLD(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .batt     (batt),
    .batt_vld (batt_vld),
    .spd      (spd),
    .spd_vld  (spd_vld),
    .en_steer (en_steer),
    .moving   (moving),
    .ovr_spd  (ovr_spd),
    .batt_low (batt_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic [2:0] mask;
    logic [2:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [2:0] M_MOV = 3'b100;
  localparam logic [2:0] M_OVR = 3'b010;
  localparam logic [2:0] M_BAT = 3'b001;

  task automatic push_exp(input string nm, input int at, input logic [2:0] m, input logic [2:0] v);
    exp_t e;
    e.name = nm;
    e.cyc  = at;
    e.mask = m;
    e.val  = v;
    sbq.push_back(e);
  endtask

  // Monitor: {moving, ovr_spd, batt_low} compared mid-cycle against due entries.
  always @(negedge clk) begin
    logic [2:0] got;
    got = {moving, ovr_spd, batt_low};
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        n_vec++;
        if ((got & sbq[i].mask) !== (sbq[i].val & sbq[i].mask)) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got {mov,ovr,bat}=%b required %b (mask %b)",
                   sbq[i].name, cyc, got, sbq[i].val, sbq[i].mask);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic bstrobe(input logic [11:0] v);
    batt     = v;
    batt_vld = 1'b1;
    step();
    batt_vld = 1'b0;
  endtask

  task automatic sstrobe(input int v);
    spd     = 12'(v);
    spd_vld = 1'b1;
    step();
    spd_vld = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_exp(nm, cyc, 3'b111, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int c;
    step();
    do_reset("reset_init");

    // Battery debounce
    repeat (15) bstrobe(12'h7FF);
    push_exp("t1_15low", cyc, M_BAT, 3'b000);
    batt = 12'h000;
    step_n(2);
    push_exp("t1_unstrobed", cyc, M_BAT, 3'b000);
    bstrobe(12'h7FF);
    push_exp("t1_16low", cyc, M_BAT, 3'b001);

    do_reset("reset_t1");
    repeat (9) bstrobe(12'h7FF);
    bstrobe(12'h800);
    push_exp("t1_restart", cyc, M_BAT, 3'b000);
    repeat (15) bstrobe(12'h7FF);
    push_exp("t1_15after", cyc, M_BAT, 3'b000);
    bstrobe(12'h7FF);
    push_exp("t1_16after", cyc, M_BAT, 3'b001);

    // Battery hysteresis
    repeat (20) bstrobe(12'h820);
    push_exp("t2_band", cyc, M_BAT, 3'b001);
    repeat (7) bstrobe(12'h840);
    push_exp("t2_pend7", cyc, M_BAT, 3'b001);
    bstrobe(12'h83F);
    push_exp("t2_abort", cyc, M_BAT, 3'b001);
    repeat (15) bstrobe(12'h840);
    push_exp("t2_rec15", cyc, M_BAT, 3'b001);
    bstrobe(12'h840);
    push_exp("t2_rec16", cyc, M_BAT, 3'b000);

    // Overspeed assert and hold
    sstrobe(1537);
    c = cyc;
    push_exp("t3_pre", c, M_OVR, 3'b000);
    push_exp("t3_assert", c + 1, M_OVR, 3'b010);
    sstrobe(0);
    push_exp("t3_mid", c + 50, M_OVR, 3'b010);
    push_exp("t3_hold_last", c + 100, M_OVR, 3'b010);
    push_exp("t3_release", c + 101, M_OVR, 3'b000);
    step_n(105);
    sstrobe(1536);
    push_exp("t3_eq_th", cyc + 1, M_OVR, 3'b000);
    step_n(3);

    // Negative saturation and release band
    sstrobe(-2048);
    c = cyc;
    push_exp("t4_neg_sat", c + 1, M_OVR, 3'b010);
    sstrobe(1500);
    push_exp("t4_band", c + 105, M_OVR, 3'b010);
    step_n(110);
    sstrobe(1472);
    c = cyc;
    push_exp("t4_still", c, M_OVR, 3'b010);
    push_exp("t4_release", c + 1, M_OVR, 3'b000);
    step_n(3);

    // Moving gating
    en_steer = 1'b1;
    sstrobe(-32);
    push_exp("t5_neg32", cyc + 1, M_MOV, 3'b100);
    sstrobe(31);
    push_exp("t5_31", cyc + 1, M_MOV, 3'b000);
    step_n(2);
    sstrobe(500);
    push_exp("t5_500", cyc + 1, M_MOV | M_OVR, 3'b100);
    step_n(2);
    en_steer = 1'b0;
    step();
    push_exp("t5_drop", cyc, M_MOV, 3'b000);
    en_steer = 1'b1;
    step_n(2);
    push_exp("t5_reenable", cyc, M_MOV, 3'b100);
    en_steer = 1'b0;
    sstrobe(500);
    push_exp("t5_drop_strobe", cyc, M_MOV, 3'b000);
    push_exp("t5_drop_next", cyc + 1, M_MOV, 3'b000);
    step_n(2);

    // Reset mid-operation, with a coincident battery and speed strobe
    do_reset("reset_t6a");
    repeat (9) bstrobe(12'h7FF);
    batt     = 12'h7FF;
    batt_vld = 1'b1;
    spd      = 12'sd2000;
    spd_vld  = 1'b1;
    step();
    batt_vld = 1'b0;
    spd_vld  = 1'b0;
    push_exp("t6_both", cyc + 1, M_OVR | M_BAT, 3'b010);
    step_n(5);
    do_reset("reset_mid");
    repeat (15) bstrobe(12'h7FF);
    push_exp("t6_15low", cyc, M_OVR | M_BAT, 3'b000);
    bstrobe(12'h7FF);
    push_exp("t6_16low", cyc, M_BAT, 3'b001);
    sstrobe(2000);
    push_exp("t6_ovr_and_bat", cyc + 1, M_OVR | M_BAT, 3'b011);
    step_n(3);

    for (int i = 0; i < 200 && sbq.size() > 0; i++) step();
    if (sbq.size() > 0) begin
      n_fail += sbq.size();
      $display("FAIL scoreboard_drain: %0d expectations unchecked, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
